// File: rtl/reduce_engine_pkg.sv
// Shared definitions for reduce_engine: mode encodings and FSM state type.
// Saturating sums are selected with the REDUCE_ENGINE_SAT_EN macro.
package reduce_engine_pkg;

    localparam logic [1:0] MODE_USUM = 2'b00;
    localparam logic [1:0] MODE_SSUM = 2'b01;
    localparam logic [1:0] MODE_UMAX = 2'b10;
    localparam logic [1:0] MODE_UMIN = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/reduce_alu.sv
// Combinational combine step: next_acc = op(acc, operand) for the selected mode.
// REDUCE_ENGINE_SAT_EN clamps overflowing sums instead of wrapping them.
module reduce_alu
    import reduce_engine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] next_acc,
    output logic             step_overflow
);

    logic [WIDTH:0] sum;

    assign sum = {1'b0, acc} + {1'b0, operand};

    always_comb begin
        next_acc      = sum[WIDTH-1:0];
        step_overflow = 1'b0;
        case (mode)
            MODE_USUM: begin
                step_overflow = sum[WIDTH];
`ifdef REDUCE_ENGINE_SAT_EN
                if (sum[WIDTH]) next_acc = '1;
`endif
            end
            MODE_SSUM: begin
                // Same-sign addends whose sum flips sign overflowed.
                step_overflow = (acc[WIDTH-1] == operand[WIDTH-1]) &&
                                (sum[WIDTH-1] != acc[WIDTH-1]);
`ifdef REDUCE_ENGINE_SAT_EN
                if (step_overflow)
                    next_acc = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
`endif
            end
            MODE_UMAX: next_acc = (acc >= operand) ? acc : operand;
            MODE_UMIN: next_acc = (acc <= operand) ? acc : operand;
            default:   next_acc = sum[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/reduce_engine.sv
// Multi-cycle reduction engine: folds NUM_OPS latched operands, one per clock.
// Handshake: start is a level sampled only in IDLE; done pulses one cycle with result valid.
module reduce_engine
    import reduce_engine_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [NUM_OPS*WIDTH-1:0] ops,
    output logic [WIDTH-1:0]         result,
    output logic                     done,
    output logic                     busy,
    output logic                     overflow,
    output logic [1:0]               fsm_state
);

    localparam int IW = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1;

    state_t                   state;
    logic [NUM_OPS*WIDTH-1:0] ops_q;
    logic [1:0]               mode_q;
    logic [WIDTH-1:0]         acc;
    logic [IW-1:0]            idx;
    logic [WIDTH-1:0]         operand;
    logic [WIDTH-1:0]         alu_next;
    logic                     alu_ov;

    always_comb begin
        operand = '0;
        for (int k = 0; k < NUM_OPS; k++) begin
            if (idx == IW'(k)) operand = ops_q[k*WIDTH +: WIDTH];
        end
    end

    reduce_alu #(.WIDTH(WIDTH)) u_alu (
        .acc           (acc),
        .operand       (operand),
        .mode          (mode_q),
        .next_acc      (alu_next),
        .step_overflow (alu_ov)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ops_q    <= '0;
            mode_q   <= '0;
            acc      <= '0;
            idx      <= '0;
            result   <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ops_q    <= ops;
                        mode_q   <= mode;
                        acc      <= ops[WIDTH-1:0];
                        idx      <= IW'(1);
                        overflow <= 1'b0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc      <= alu_next;
                    overflow <= overflow | alu_ov;
                    idx      <= idx + 1'b1;
                    if (idx == IW'(NUM_OPS - 1)) begin
                        result <= alu_next;
                        done   <= 1'b1;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign fsm_state = state;

endmodule

// File: tb/tb_reduce_engine.sv
// Bench for reduce_engine (WIDTH=8, NUM_OPS=4); honours REDUCE_ENGINE_SAT_EN.
module tb_reduce_engine;

    localparam int WIDTH   = 8;
    localparam int NUM_OPS = 4;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic [1:0]               mode = 2'b00;
    logic [NUM_OPS*WIDTH-1:0] ops = '0;
    logic [WIDTH-1:0]         result;
    logic                     done;
    logic                     busy;
    logic                     overflow;
    logic [1:0]               fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;

    // clock / reset
    always #5 clk = ~clk;

    reduce_engine #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .ops       (ops),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .overflow  (overflow),
        .fsm_state (fsm_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    // Reference reduction using plain integer arithmetic.
    function automatic void model_calc(input logic [1:0] m, input logic [NUM_OPS*WIDTH-1:0] v,
                                       output logic [WIDTH-1:0] r, output logic ov);
        int umax, smax, smin, a, x;
        logic [31:0] tmp;
        umax = (1 << WIDTH) - 1;
        smax = (1 << (WIDTH - 1)) - 1;
        smin = -(1 << (WIDTH - 1));
        ov = 1'b0;
        a = int'(v[WIDTH-1:0]);
        if (m == 2'b01 && a > smax) a = a - (1 << WIDTH);
        for (int i = 1; i < NUM_OPS; i++) begin
            x = int'(v[i*WIDTH +: WIDTH]);
            case (m)
                2'b00: begin
                    a = a + x;
                    if (a > umax) begin
                        ov = 1'b1;
`ifdef REDUCE_ENGINE_SAT_EN
                        a = umax;
`else
                        a = a - (1 << WIDTH);
`endif
                    end
                end
                2'b01: begin
                    if (x > smax) x = x - (1 << WIDTH);
                    a = a + x;
                    if (a > smax) begin
                        ov = 1'b1;
`ifdef REDUCE_ENGINE_SAT_EN
                        a = smax;
`else
                        a = a - (1 << WIDTH);
`endif
                    end else if (a < smin) begin
                        ov = 1'b1;
`ifdef REDUCE_ENGINE_SAT_EN
                        a = smin;
`else
                        a = a + (1 << WIDTH);
`endif
                    end
                end
                2'b10: if (x > a) a = x;
                default: if (x < a) a = x;
            endcase
        end
        tmp = a;
        r = tmp[WIDTH-1:0];
    endfunction

    // Model of observable timing: done NUM_OPS-1 edges after the accepting edge.
    logic             model_valid = 1'b0;
    logic             exp_busy = 1'b0;
    logic             exp_done = 1'b0;
    logic [WIDTH-1:0] exp_result = '0;
    logic             exp_ov = 1'b0;
    logic             ov_known = 1'b1;
    logic [WIDTH-1:0] pend_result;
    logic             pend_ov;
    int               remaining = 0;
    logic [WIDTH-1:0] exp_q[$];

    always @(posedge clk) begin
        model_valid = 1'b1;
        if (reset) begin
            exp_busy = 1'b0; exp_done = 1'b0; exp_result = '0;
            exp_ov = 1'b0; ov_known = 1'b1; remaining = 0;
            exp_q.delete();
        end else if (exp_done) begin
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end else if (exp_busy) begin
            remaining--;
            if (remaining == 0) begin
                exp_done   = 1'b1;
                exp_result = exp_q.pop_front();
                exp_ov     = pend_ov;
                ov_known   = 1'b1;
            end
        end else if (start) begin
            model_calc(mode, ops, pend_result, pend_ov);
            exp_q.push_back(pend_result);
            exp_busy  = 1'b1;
            remaining = NUM_OPS - 1;
            ov_known  = 1'b0;
        end
    end

    // Compare process
    always @(negedge clk) begin
        if (model_valid) begin
            check("done", done, exp_done);
            check("busy", busy, exp_busy);
            check("result", result, exp_result);
            if (ov_known) check("overflow", overflow, exp_ov);
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic run_op(input string name, input logic [1:0] m,
                          input logic [7:0] o0, input logic [7:0] o1,
                          input logic [7:0] o2, input logic [7:0] o3,
                          input logic [7:0] lit_r, input logic lit_ov);
        int lat;
        lat = 0;
        mode  = m;
        ops   = {o3, o2, o1, o0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        // scramble inputs while the operation is in flight
        mode = 2'($urandom_range(0, 3));
        ops  = {$urandom, $urandom};
        if (done !== 1'b1) begin
            lat = 0;
            for (int i = 2; i <= 20; i++) begin
                @(negedge clk);
                if (done === 1'b1) begin
                    lat = i;
                    break;
                end
            end
        end
        check({name, "_latency"}, lat, NUM_OPS);
        check({name, "_result"}, result, lit_r);
        check({name, "_overflow"}, overflow, lit_ov);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_result", result, 0);
        check("reset_busy", busy, 0);
        check("reset_state", fsm_state, 0);
        @(negedge clk);

`ifdef REDUCE_ENGINE_SAT_EN
        run_op("usum", 2'b00, 8'h01, 8'h02, 8'hFF, 8'hFE, 8'hFF, 1'b1);
`else
        run_op("usum", 2'b00, 8'h01, 8'h02, 8'hFF, 8'hFE, 8'h00, 1'b1);
`endif
        run_op("umax", 2'b10, 8'hFE, 8'h01, 8'h01, 8'h04, 8'hFE, 1'b0);
        run_op("umin", 2'b11, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h01, 1'b0);
        run_op("ssum", 2'b01, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'h00, 1'b0);
`ifdef REDUCE_ENGINE_SAT_EN
        run_op("ssum_ovf", 2'b01, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h7F, 1'b1);
        run_op("ssum_neg", 2'b01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h80, 1'b1);
`else
        run_op("ssum_ovf", 2'b01, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h80, 1'b1);
        run_op("ssum_neg", 2'b01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h7F, 1'b1);
`endif
        run_op("usum_small", 2'b00, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA0, 1'b0);

        // start held two cycles plus a retrigger inside RUN: one done only
        d0 = done_seen;
        mode = 2'b00;
        ops  = {8'h04, 8'h03, 8'h02, 8'h01};
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("start_hold_done_count", done_seen - d0, 1);
        check("start_hold_result", result, 8'h0A);

        // reset in the middle of RUN aborts without a done pulse
        d0 = done_seen;
        mode = 2'b10;
        ops  = {8'h09, 8'h08, 8'h07, 8'h06};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_overflow", overflow, 0);
        repeat (8) @(negedge clk);
        check("abort_done_count", done_seen - d0, 0);
        run_op("after_abort", 2'b11, 8'h33, 8'h22, 8'h44, 8'h55, 8'h22, 1'b0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reduce_engine.md
REDUCE_ENGINE -- requirements
Module: reduce_engine

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be at least 2.
REQ-002 Parameter NUM_OPS, default 4: number of operands reduced per operation; SHALL be at least 2.
REQ-003 clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 start  input  1: level request, sampled only in IDLE.
REQ-006 mode  input  2: operation select: 00 unsigned sum, 01 signed sum, 10 unsigned max, 11 unsigned min.
REQ-007 ops  input  NUM_OPS*WIDTH: packed operands, with operand k at bits [k*WIDTH +: WIDTH].
REQ-008 result  output  WIDTH: registered reduction result.
REQ-009 done  output  1: one-cycle pulse marking result valid.
REQ-010 busy  output  1: high in RUN and DONE.
REQ-011 overflow  output  1: sticky arithmetic overflow flag for the current operation.

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-013 IDLE with start=1 at an edge SHALL:
- latch ops and mode;
- load the accumulator with operand 0;
- set the operand index to 1;
- clear overflow;
- enter RUN.
REQ-014 RUN SHALL combine one operand per edge: the accumulator takes op(acc, ops[idx]), and idx increments.
REQ-015 On the edge that combines operand NUM_OPS-1, the FSM SHALL enter DONE and update result.
REQ-016 Latency: with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+NUM_OPS-1.
REQ-017 DONE SHALL always return to IDLE on the next edge.
REQ-018 start SHALL be ignored in RUN and DONE. If start is still high once the FSM is back in IDLE, a new operation SHALL begin.
REQ-019 Operand and mode changes after the sampling edge SHALL NOT affect the operation in flight.
REQ-020 Sums SHALL wrap modulo 2^WIDTH.
REQ-021 Overflow detection for sums:
- unsigned: set overflow on any carry out of bit WIDTH-1;
- signed: set overflow when both addends have the same sign and the sum's sign differs.
REQ-022 Max and min modes SHALL compare unsigned and SHALL never set overflow.
REQ-023 result SHALL hold its value from DONE until the next DONE. overflow SHALL hold until the next accepted start.

Reset
REQ-024 reset=1 at an edge SHALL force the following:
- FSM state to IDLE;
- result, done, busy, overflow, accumulator and idx to 0.
REQ-025 reset SHALL take priority over start and over any in-progress operation. An aborted operation SHALL produce no done pulse.

Configuration
REQ-026 Macro REDUCE_ENGINE_SAT_EN controls sum saturation.
REQ-027 With REDUCE_ENGINE_SAT_EN defined, an overflowing sum step SHALL clamp the accumulator:
- unsigned sum: all ones;
- signed sum: maximum positive value, or minimum negative value, according to the overflow direction.
- overflow SHALL still be set.
REQ-028 Without REDUCE_ENGINE_SAT_EN defined, sums SHALL wrap as in REQ-020.

Structure
REQ-029 Package reduce_engine_pkg SHALL contain:
- the mode encoding constants;
- the FSM state typedef.
REQ-030 The combine step SHALL be a combinational sub-module reduce_alu, parametrised by WIDTH, taking (acc, operand, mode) and producing (next_acc, step_overflow).

Verification (WIDTH=8, NUM_OPS=4)
REQ-031 Unsigned sum: mode=00, ops 01,02,FF,FE, start pulsed.
- done SHALL pulse 4 cycles after the sampling edge.
- Without the macro: result=00, overflow=1.
- With the macro: result=FF, overflow=1.
REQ-032 Unsigned max: mode=10, ops FE,01,01,04 -> result=FE, overflow=0.
REQ-033 Unsigned min: mode=11, ops 01,FF,FF,FF -> result=01, overflow=0.
REQ-034 Signed sum: mode=01, ops FF,01,FF,01 -> result=00, overflow=0.
- Also mode=01, ops 7F,01,00,00 -> overflow=1; result=80 without the macro, 7F with it.
REQ-035 Start behaviour: start held high for 2 cycles -> exactly one done pulse, and a second start asserted in RUN is ignored.
REQ-036 Reset mid-RUN: reset pulsed in RUN -> no done pulse, all outputs 0, and the next start runs normally.
